// File: rtl/layer_compositor.sv
// N-layer priority compositor with colour key and blink, plus double-buffered sprite positions.
// Pixel latency 2 clk, 1 pixel/clk; position writes stall (pos_wr_ready=0) only on frame_start.
module layer_compositor #(
   parameter int          NUM_LAYERS  = 4,
   parameter int          NUM_SPRITES = 2,
   parameter logic [23:0] BG_COLOR    = 24'h000000,
   parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
   parameter int          BLINK_SHIFT = 4,
   localparam int         IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       de_in,
   input  logic                       frame_start,
   input  logic [NUM_LAYERS-1:0]      layer_en,
   input  logic [24*NUM_LAYERS-1:0]   layer_color,
   input  logic [NUM_LAYERS-1:0]      blink_en,
   input  logic                       pos_wr_valid,
   output logic                       pos_wr_ready,
   input  logic [IDX_W-1:0]           pos_wr_idx,
   input  logic [9:0]                 pos_wr_x,
   input  logic [9:0]                 pos_wr_y,
   output logic [10*NUM_SPRITES-1:0]  sprite_x,
   output logic [10*NUM_SPRITES-1:0]  sprite_y,
   output logic [7:0]                 frame_cnt,
   output logic                       de_out,
   output logic [7:0]                 r,
   output logic [7:0]                 g,
   output logic [7:0]                 b
);

   typedef struct packed {
      logic                             de;
      logic [NUM_LAYERS-1:0]            vis;
      logic [NUM_LAYERS-1:0][23:0]      color;
   } s1_t;

   s1_t                              s1_d;
   s1_t                              s1_q;
   logic [23:0]                      pix_c;
   logic                             wr_acc;
   logic [NUM_SPRITES-1:0][9:0]      cur_x;
   logic [NUM_SPRITES-1:0][9:0]      cur_y;
   logic [NUM_SPRITES-1:0][9:0]      shd_x;
   logic [NUM_SPRITES-1:0][9:0]      shd_y;
   logic [NUM_SPRITES-1:0]           pending;

   // Blink gate reads the counter as registered before this cycle's increment.
   always_comb begin
      s1_d.de    = de_in;
      s1_d.color = layer_color;
      s1_d.vis   = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         s1_d.vis[i] = layer_en[i]
                     && (layer_color[24*i +: 24] != KEY_COLOR)
                     && !(blink_en[i] && frame_cnt[BLINK_SHIFT]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= '0;
      end else begin
         s1_q <= s1_d;
      end
   end

   // Later (higher-index) visible layers overwrite earlier ones.
   always_comb begin
      pix_c = BG_COLOR;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (s1_q.vis[i]) begin
            pix_c = s1_q.color[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         de_out    <= 1'b0;
         {r, g, b} <= 24'h000000;
      end else begin
         de_out    <= s1_q.de;
         {r, g, b} <= s1_q.de ? pix_c : 24'h000000;
      end
   end

   assign pos_wr_ready = ~frame_start;
   assign wr_acc       = pos_wr_valid & pos_wr_ready;

   // Writes never land on a frame_start cycle, so commit and shadow update cannot collide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_x   <= '0;
         cur_y   <= '0;
         shd_x   <= '0;
         shd_y   <= '0;
         pending <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (frame_start && pending[i]) begin
               cur_x[i]   <= shd_x[i];
               cur_y[i]   <= shd_y[i];
               pending[i] <= 1'b0;
            end
            if (wr_acc && (pos_wr_idx == IDX_W'(i))) begin
               shd_x[i]   <= pos_wr_x;
               shd_y[i]   <= pos_wr_y;
               pending[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= 8'd0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign sprite_x = cur_x;
   assign sprite_y = cur_y;

endmodule

// File: tb/tb_layer_compositor.sv
// Randomised bench for layer_compositor: pixel results go through an expectation queue
// drained by a monitor; sprite registers and frame counter are checked against a model.
module tb_layer_compositor;

   localparam int          NL  = 4;
   localparam int          NS  = 2;
   localparam logic [23:0] KEY = 24'hFF00FF;
   localparam logic [23:0] BG  = 24'h000000;
   localparam int          BS  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          de_in = 1'b0;
   logic          frame_start = 1'b0;
   logic [NL-1:0] layer_en = '0;
   logic [95:0]   layer_color = '0;
   logic [NL-1:0] blink_en = '0;
   logic          pos_wr_valid = 1'b0;
   logic          pos_wr_ready;
   logic          pos_wr_idx = 1'b0;
   logic [9:0]    pos_wr_x = '0;
   logic [9:0]    pos_wr_y = '0;
   logic [19:0]   sprite_x;
   logic [19:0]   sprite_y;
   logic [7:0]    frame_cnt;
   logic          de_out;
   logic [7:0]    r;
   logic [7:0]    g;
   logic [7:0]    b;

   layer_compositor #(
      .NUM_LAYERS(NL), .NUM_SPRITES(NS), .BG_COLOR(BG),
      .KEY_COLOR(KEY), .BLINK_SHIFT(BS)
   ) dut (
      .clk(clk), .reset(reset), .de_in(de_in), .frame_start(frame_start),
      .layer_en(layer_en), .layer_color(layer_color), .blink_en(blink_en),
      .pos_wr_valid(pos_wr_valid), .pos_wr_ready(pos_wr_ready), .pos_wr_idx(pos_wr_idx),
      .pos_wr_x(pos_wr_x), .pos_wr_y(pos_wr_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .frame_cnt(frame_cnt), .de_out(de_out), .r(r), .g(g), .b(b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        de;
      logic [23:0] pix;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   // reference state
   int   m_fc;
   int   m_cx[NS];
   int   m_cy[NS];
   int   m_sx[NS];
   int   m_sy[NS];
   bit   m_pend[NS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic logic [23:0] ref_pix(input logic de, input logic [NL-1:0] en,
                                           input logic [95:0] col, input logic [NL-1:0] bl,
                                           input int fc);
      logic [23:0] c;
      bit blink_off;
      if (!de) return 24'h000000;
      blink_off = ((fc >> BS) & 1) != 0;
      for (int i = NL - 1; i >= 0; i--) begin
         c = col[24*i +: 24];
         if (en[i] && c != KEY && !(bl[i] && blink_off)) return c;
      end
      return BG;
   endfunction

   task automatic model_clear();
      m_fc = 0;
      for (int i = 0; i < NS; i++) begin
         m_cx[i] = 0; m_cy[i] = 0; m_sx[i] = 0; m_sy[i] = 0; m_pend[i] = 0;
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < NS; i++) begin
         check($sformatf("sprite_x[%0d]", i), 32'(sprite_x[10*i +: 10]), 32'(m_cx[i]));
         check($sformatf("sprite_y[%0d]", i), 32'(sprite_y[10*i +: 10]), 32'(m_cy[i]));
      end
      check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
   endtask

   // Called at a negedge; returns at the next negedge.
   task automatic step(input logic de, input logic [NL-1:0] en, input logic [95:0] col,
                       input logic [NL-1:0] bl, input logic fs, input logic wv,
                       input logic idx, input logic [9:0] x, input logic [9:0] y);
      exp_t e;
      de_in = de; layer_en = en; layer_color = col; blink_en = bl;
      frame_start = fs; pos_wr_valid = wv; pos_wr_idx = idx; pos_wr_x = x; pos_wr_y = y;
      e.due = cyc + 2;
      e.de  = de;
      e.pix = ref_pix(de, en, col, bl, m_fc);
      exp_q.push_back(e);
      #1;
      check("pos_wr_ready", 32'(pos_wr_ready), 32'(!fs));
      if (fs) begin
         for (int i = 0; i < NS; i++) begin
            if (m_pend[i]) begin
               m_cx[i] = m_sx[i]; m_cy[i] = m_sy[i]; m_pend[i] = 0;
            end
         end
         m_fc = (m_fc + 1) % 256;
      end else if (wv && int'(idx) < NS) begin
         m_sx[idx] = int'(x); m_sy[idx] = int'(y); m_pend[idx] = 1;
      end
      @(negedge clk);
      check_regs();
   endtask

   task automatic pix(input logic [NL-1:0] en, input logic [95:0] col, input logic [NL-1:0] bl);
      step(1'b1, en, col, bl, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   task automatic wr(input logic fs, input logic idx, input logic [9:0] x, input logic [9:0] y);
      step(1'b1, layer_en, layer_color, blink_en, fs, 1'b1, idx, x, y);
   endtask

   task automatic frame();
      step(1'b1, layer_en, layer_color, blink_en, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   // Called at a negedge with the clock edge count `cyc`; returns at a negedge.
   task automatic do_reset(input int n);
      exp_t e;
      reset = 1'b1;
      pos_wr_valid = 1'b0;
      frame_start = 1'b0;
      exp_q.delete();
      e.de = 1'b0; e.pix = 24'h000000;
      e.due = cyc + 1;
      exp_q.push_back(e);
      #1;
      model_clear();
      check("rst rgb", 32'({r, g, b}), 32'h0);
      check("rst de_out", 32'(de_out), 32'h0);
      check_regs();
      for (int j = 0; j < n; j++) begin
         e.due = cyc + 2;
         exp_q.push_back(e);
         @(negedge clk);
      end
      reset = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
               check("stale expectation", 32'(e.due), 32'(cyc));
            end else begin
               check("de_out", 32'(de_out), 32'(e.de));
               check("rgb", 32'({r, g, b}), 32'(e.pix));
            end
         end
      end
   end

   initial begin : driver
      logic [95:0] col;
      logic [NL-1:0] bl;
      model_clear();
      @(negedge clk);
      do_reset(3);

      // idle: no layers -> background
      pix(4'b0000, 96'h0, 4'b0000);
      pix(4'b0000, 96'h0, 4'b0000);
      // priority, back to back
      pix(4'b0011, {24'h0, 24'h0, 24'h00FF00, 24'hFF0000}, 4'b0000);
      pix(4'b1001, {24'h0000FF, 24'h0, 24'h00FF00, 24'hFF0000}, 4'b0000);
      pix(4'b0001, {24'h0000FF, 24'h0, 24'h00FF00, 24'hFF0000}, 4'b0000);
      // colour key
      pix(4'b0110, {24'h0, KEY, 24'h123456, 24'h0}, 4'b0000);
      pix(4'b0110, {24'h0, KEY, KEY, 24'h0}, 4'b0000);
      // de low blanks the output
      step(1'b0, 4'b1111, {4{24'hABCDEF}}, 4'b0000, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
      // blink over 32 frames
      pix(4'b0010, {24'h0, 24'h0, 24'h00FF00, 24'h0}, 4'b0010);
      for (int k = 0; k < 32; k++) begin
         frame();
         pix(4'b0010, {24'h0, 24'h0, 24'h00FF00, 24'h0}, 4'b0010);
      end
      // position writes and commit
      wr(1'b0, 1'b0, 10'd100, 10'd200);
      pix(4'b0000, 96'h0, 4'b0000);
      frame();
      wr(1'b0, 1'b1, 10'd10, 10'd20);
      wr(1'b0, 1'b1, 10'd30, 10'd40);
      frame();
      // write colliding with frame_start: held one cycle, commits a frame later
      wr(1'b1, 1'b0, 10'd5, 10'd6);
      wr(1'b0, 1'b0, 10'd5, 10'd6);
      pix(4'b0000, 96'h0, 4'b0000);
      frame();
      // reset with a pending write discards it
      wr(1'b0, 1'b1, 10'd77, 10'd88);
      do_reset(2);
      frame();
      pix(4'b0000, 96'h0, 4'b0000);

      // randomised traffic
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset($urandom_range(1, 3));
         end
         for (int i = 0; i < NL; i++) begin
            col[24*i +: 24] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom());
            bl[i] = ($urandom_range(0, 3) == 0);
         end
         step($urandom_range(0, 7) != 0, 4'($urandom()), col, bl,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 1'($urandom()),
              10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
      end

      pos_wr_valid = 1'b0;
      frame_start = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      check("drain timeout", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
